inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Program-counter and fetch sequencer that drives the instruction ROM's address port and receives its combinational instruction word.
Holds the PC and sequences execution: start, increment, absolute/relative branch, stall, halt.
Reports a cycle count and completion to the testbench/top level.
Sits between the top-level control/decoder and the instruction ROM.

Parameters:
A, 10, instruction address width (matches ROM depth 2**A)
W, 9, instruction word width
OW, 6, relative-branch offset width (signed, two's complement)
HALT_WORD, 9'b111111111, instruction encoding that terminates the program
CW, 16, cycle-counter width

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; clears all state
Start  input  1  one-cycle pulse: begin execution at StartAddr
StartAddr  input  A  first instruction address, sampled when Start accepted
Stall  input  1  hold PC and instruction this cycle
BranchAbs  input  1  load PC with Target next cycle
Target  input  A  absolute branch target
BranchRel  input  1  PC <= PC + sign-extended Offset
Offset  input  OW  signed relative displacement
InstIn  input  W  instruction word from ROM for current InstAddress (combinational return)
InstAddress  output  A  current PC, driven to ROM
Instr  output  W  InstIn passed through when InstValid=1, else 0
InstValid  output  1  1 when in RUN and Instr is executable this cycle
Done  output  1  1 in HALTED state
Wrapped  output  1  sticky: sequential increment wrapped 2**A-1 -> 0
CycleCnt  output  CW  cycles spent in RUN, stalls included

Behaviour:
- Reset (sync, highest priority): state=IDLE, PC=0, InstValid=0, Done=0, Wrapped=0, CycleCnt=0, Instr=0.
- States: IDLE, RUN, HALTED. Encoding is free.
- IDLE:
  - Start=1 -> PC<=StartAddr, CycleCnt<=0, Wrapped<=0, next=RUN.
  - Otherwise hold all state.
- RUN:
  - InstAddress=PC, driven combinationally from the register.
  - InstValid=1 and Instr=InstIn in the same cycle (ROM read is zero latency).
  - CycleCnt increments every RUN cycle, saturating at 2**CW-1.
- RUN per-cycle PC priority, highest first:
  1. Stall=1 -> PC holds; halt detection and branches ignored.
  2. InstIn==HALT_WORD -> next=HALTED, PC holds; branch inputs ignored.
  3. BranchAbs=1 -> PC<=Target.
  4. BranchRel=1 -> PC<=PC + sext(Offset), modulo 2**A. Relative to the current PC, not PC+1. Does not set Wrapped.
  5. Else PC<=PC+1. On the transition 2**A-1 -> 0, set Wrapped=1 (sticky until Start or Reset).
- BranchAbs and BranchRel both high: BranchAbs wins.
- Start while in RUN is ignored.
- HALTED:
  - Done=1, InstValid=0, PC and CycleCnt frozen.
  - Start=1 -> restart exactly as from IDLE; Done falls the next cycle.
- Reset asserted mid-RUN or in HALTED: all state returns to reset values on that edge; in-flight branch inputs are discarded.
- Inputs sampled only on Clk edges; no combinational path from the branch inputs to InstAddress.

Test Plan:
- Reset, Start with StartAddr=0, ROM words 0..4 non-halt, word 5=HALT_WORD -> InstAddress steps 0,1,2,3,4,5. Done=1 from the cycle after PC=5. CycleCnt=6. InstValid low in HALTED.
- At PC=3 assert BranchAbs with Target=20 -> next InstAddress=20. At PC=20 assert BranchRel with Offset=6'b111100 (-4) -> next InstAddress=16.
- Stall high for 3 cycles at PC=7 -> InstAddress stays 7 for 4 cycles total. CycleCnt advances by 4. A HALT_WORD present at PC=7 during the stall is ignored until Stall drops.
- Start with StartAddr=1022, no halt -> PC 1022, 1023, 0; Wrapped=1 when PC=0.
- BranchRel at PC=1 with Offset=-3 -> PC=1022; Wrapped stays 0.
- BranchAbs and BranchRel asserted together (Target=9) -> PC=9.
- HALT_WORD with BranchAbs in the same cycle -> HALTED, PC unchanged.
- Reset pulse mid-RUN at PC=12 -> next cycle PC=0, state IDLE, CycleCnt=0, Done=0, InstValid=0.
- Start in HALTED with StartAddr=40 -> RUN at PC=40, Done=0, CycleCnt restarts from 0.

Source files
------------

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencer for the instruction ROM.
// It sequences start, increment, absolute and relative branches, stall and halt.
module inst_fetch #(
    parameter int              A         = 10,
    parameter int              W         = 9,
    parameter int              OW        = 6,
    parameter logic [W-1:0]    HALT_WORD = {W{1'b1}},
    parameter int              CW        = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [A-1:0]  StartAddr,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic [A-1:0]  Target,
    input  logic          BranchRel,
    input  logic [OW-1:0] Offset,
    input  logic [W-1:0]  InstIn,
    output logic [A-1:0]  InstAddress,
    output logic [W-1:0]  Instr,
    output logic          InstValid,
    output logic          Done,
    output logic          Wrapped,
    output logic [CW-1:0] CycleCnt,
    output logic [1:0]    DbgState
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [A-1:0]  off_ext;

    assign off_ext = {{(A-OW){Offset[OW-1]}}, Offset};

    // Branch inputs only reach pc_d, never InstAddress, so the ROM address is purely registered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!Stall) begin
                    if (InstIn == HALT_WORD) begin
                        state_d = S_HALTED;
                    end else if (BranchAbs) begin
                        pc_d = Target;
                    end else if (BranchRel) begin
                        pc_d = pc_q + off_ext;
                    end else begin
                        pc_d = pc_q + 1'b1;
                        // Only sequential roll-over is sticky; relative wrap-around is not.
                        if (pc_q == {A{1'b1}}) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_RUN);
        done_d  = (state_d == S_HALTED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign InstAddress = pc_q;
    assign Instr       = valid_q ? InstIn : '0;
    assign InstValid   = valid_q;
    assign Done        = done_q;
    assign Wrapped     = wrap_q;
    assign CycleCnt    = cnt_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios and random traffic scored against a
// cycle-level reference model through an expected-output queue.
module tb_inst_fetch;

    localparam logic [8:0] HALT = 9'b111111111;

    logic        clk = 1'b0;
    logic        Reset, Start, Stall, BranchAbs, BranchRel;
    logic [9:0]  StartAddr, Target;
    logic [5:0]  Offset;
    logic [8:0]  InstIn;
    logic [9:0]  InstAddress;
    logic [8:0]  Instr;
    logic        InstValid, Done, Wrapped;
    logic [15:0] CycleCnt;
    logic [1:0]  DbgState;

    // Small-counter instance used only for saturation.
    logic        s_reset, s_start;
    logic [9:0]  s_addr;
    logic [8:0]  s_instr;
    logic        s_valid, s_done, s_wrap;
    logic [3:0]  s_cnt;
    logic [1:0]  s_dbg;

    logic [8:0]  rom [1024];
    logic [37:0] exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;

    int          m_state;   // 0 idle, 1 run, 2 halted
    int          m_pc, m_cnt;
    bit          m_wrap;

    always #5 clk = ~clk;

    assign InstIn = rom[InstAddress];

    inst_fetch dut (
        .Clk(clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .BranchAbs(BranchAbs), .Target(Target),
        .BranchRel(BranchRel), .Offset(Offset), .InstIn(InstIn),
        .InstAddress(InstAddress), .Instr(Instr), .InstValid(InstValid),
        .Done(Done), .Wrapped(Wrapped), .CycleCnt(CycleCnt), .DbgState(DbgState)
    );

    inst_fetch #(.CW(4)) u_sat (
        .Clk(clk), .Reset(s_reset), .Start(s_start), .StartAddr(10'd100),
        .Stall(1'b0), .BranchAbs(1'b0), .Target(10'd0),
        .BranchRel(1'b0), .Offset(6'd0), .InstIn(9'd0),
        .InstAddress(s_addr), .Instr(s_instr), .InstValid(s_valid),
        .Done(s_done), .Wrapped(s_wrap), .CycleCnt(s_cnt), .DbgState(s_dbg)
    );

    // Monitor: pops one expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [37:0] e, a;
            e = exp_q.pop_front();
            a = {InstAddress, Instr, InstValid, Done, Wrapped, CycleCnt};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_out t=%0t actual addr=%0d instr=%h v=%b d=%b w=%b cnt=%0d required addr=%0d instr=%h v=%b d=%b w=%b cnt=%0d",
                         $time, a[37:28], a[27:19], a[18], a[17], a[16], a[15:0],
                         e[37:28], e[27:19], e[18], e[17], e[16], e[15:0]);
            end
        end
    end

    task automatic clear_in();
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchAbs = 1'b0; BranchRel = 1'b0;
        StartAddr = '0; Target = '0; Offset = '0;
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_cnt = 0; m_wrap = 1'b0;
    endtask

    // Push the outputs the model predicts for this cycle, then advance the model one edge.
    task automatic tick();
        logic [37:0] e;
        int off;
        e = {10'(m_pc), (m_state == 1) ? rom[m_pc] : 9'd0, m_state == 1, m_state == 2,
             m_wrap, 16'(m_cnt)};
        exp_q.push_back(e);
        off = Offset[5] ? int'(Offset) - 64 : int'(Offset);
        if (Reset) begin
            model_reset();
        end else if (m_state != 1) begin
            if (Start) begin
                m_state = 1; m_pc = int'(StartAddr); m_cnt = 0; m_wrap = 1'b0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (!Stall) begin
                if (rom[m_pc] == HALT) m_state = 2;
                else if (BranchAbs) m_pc = int'(Target);
                else if (BranchRel) m_pc = (m_pc + off + 1024) % 1024;
                else if (m_pc == 1023) begin m_pc = 0; m_wrap = 1'b1; end
                else m_pc++;
            end
        end
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic rom_fill(input int halt_pct);
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 99) < halt_pct) ? HALT : 9'($urandom_range(0, 510));
    endtask

    task automatic do_start(input int addr);
        Start = 1'b1; StartAddr = 10'(addr); tick();
    endtask

    initial begin
        rom_fill(0);
        clear_in();
        Reset = 1'b1;
        s_reset = 1'b1; s_start = 1'b0;
        model_reset();
        @(posedge clk); #1;
        Reset = 1'b0; s_reset = 1'b0;
        chk("reset_addr", int'(InstAddress), 0);
        chk("reset_valid", int'(InstValid), 0);
        chk("reset_done", int'(Done), 0);
        tick(); tick();

        // Straight-line program ending in a halt word at address 5.
        rom[5] = HALT;
        do_start(0);
        for (int i = 0; i < 6; i++) tick();
        chk("halt_done", int'(Done), 1);
        chk("halt_cnt", int'(CycleCnt), 6);
        chk("halt_valid", int'(InstValid), 0);
        chk("halt_addr", int'(InstAddress), 5);
        tick(); tick();
        rom[5] = 9'd3;

        // Absolute then relative branch.
        do_start(0);
        tick(); tick(); tick();
        BranchAbs = 1'b1; Target = 10'd20; tick();
        chk("babs_addr", int'(InstAddress), 20);
        BranchRel = 1'b1; Offset = 6'b111100; tick();
        chk("brel_addr", int'(InstAddress), 16);

        // Stall over a halt word at address 7.
        Reset = 1'b1; tick();
        rom[7] = HALT;
        do_start(7);
        for (int i = 0; i < 3; i++) begin Stall = 1'b1; tick(); end
        chk("stall_addr", int'(InstAddress), 7);
        chk("stall_cnt", int'(CycleCnt), 3);
        chk("stall_done", int'(Done), 0);
        tick();
        chk("stall_halt_done", int'(Done), 1);
        chk("stall_halt_cnt", int'(CycleCnt), 4);
        rom[7] = 9'd7;

        // Sequential wrap from the top of the address space.
        do_start(1022);
        tick(); tick();
        chk("wrap_addr", int'(InstAddress), 0);
        chk("wrap_flag", int'(Wrapped), 1);

        // Relative branch below zero does not set Wrapped.
        Reset = 1'b1; tick();
        do_start(1);
        BranchRel = 1'b1; Offset = 6'(-3); tick();
        chk("brel_neg_addr", int'(InstAddress), 1022);
        chk("brel_neg_wrap", int'(Wrapped), 0);

        // Both branches: absolute wins.
        BranchAbs = 1'b1; Target = 10'd9; BranchRel = 1'b1; Offset = 6'd5; tick();
        chk("both_addr", int'(InstAddress), 9);

        // Halt word beats a simultaneous absolute branch.
        rom[9] = HALT;
        BranchAbs = 1'b1; Target = 10'd100; tick();
        chk("halt_babs_done", int'(Done), 1);
        chk("halt_babs_addr", int'(InstAddress), 9);
        rom[9] = 9'd1;

        // Restart from HALTED, then reset mid-run.
        do_start(40);
        chk("restart_addr", int'(InstAddress), 40);
        chk("restart_done", int'(Done), 0);
        chk("restart_cnt", int'(CycleCnt), 0);
        Start = 1'b1; StartAddr = 10'd500; tick();
        chk("start_in_run_addr", int'(InstAddress), 41);
        BranchAbs = 1'b1; Target = 10'd12; tick();
        Reset = 1'b1; BranchAbs = 1'b1; Target = 10'd77; tick();
        chk("rst_addr", int'(InstAddress), 0);
        chk("rst_cnt", int'(CycleCnt), 0);
        chk("rst_valid", int'(InstValid), 0);
        chk("rst_done", int'(Done), 0);

        // Random traffic.
        rom_fill(4);
        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom_range(0, 79) == 0);
            Start     = ($urandom_range(0, 5) == 0);
            StartAddr = 10'($urandom_range(0, 1023));
            Stall     = ($urandom_range(0, 4) == 0);
            BranchAbs = ($urandom_range(0, 7) == 0);
            Target    = 10'($urandom_range(0, 1023));
            BranchRel = ($urandom_range(0, 5) == 0);
            Offset    = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 49) == 0) rom[$urandom_range(0, 1023)] = 9'($urandom_range(0, 511));
            tick();
        end

        // Saturation on the 4-bit counter instance.
        s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_cnt", int'(s_cnt), 15);
        chk("sat_valid", int'(s_valid), 1);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
